systolic_feed_ctrl: RTL and testbench
=====================================

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 Parameter MAC_WIDTH, default 4: number of systolic rows (FIFO lanes) sequenced.
REQ-002 Parameter CNT_W, default 8: width of the column-count input.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to stream one matrix; sampled only in IDLE.
REQ-006 cols  input  CNT_W  number of columns to stream per row; sampled with start; legal range 1..2^CNT_W-1.
REQ-007 matrix_in_valid  input  1  upstream indicates the matrix operand is available.
REQ-008 stall  input  1  downstream lane FIFOs cannot accept data this cycle.
REQ-009 matrix_in_request  output  1  asks upstream for the matrix operand.
REQ-010 feed_en  output  MAC_WIDTH  per-row lane read/write enable; bit i drives row i.
REQ-011 wave  output  CNT_W+1  current feed wavefront index; row i consumes column (wave - i).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle pulse on an illegal start.

Function
REQ-015 FSM states are IDLE, REQ, FEED, DRAIN and DONE; all outputs are decoded from registered state and counters.
REQ-016 IDLE with start=1 and cols!=0: latch cols; go to REQ next cycle.
REQ-017 IDLE with start=1 and cols==0: pulse err for exactly one cycle; stay in IDLE.
REQ-018 start outside IDLE is ignored; the latched cols value is not altered.
REQ-019 REQ: matrix_in_request=1; on the first cycle matrix_in_valid=1, go to FEED next cycle with wave=0.
REQ-020 matrix_in_request is 0 in every state other than REQ.
REQ-021 FEED, stall=0: feed_en[i]=1 iff i <= wave < i+cols_latched; wave increments by 1 each cycle.
REQ-022 FEED, stall=1: feed_en is all-zero and wave holds its value.
REQ-023 FEED exit: on a non-stalled cycle with wave == cols_latched+MAC_WIDTH-2, go to DRAIN and clear wave to 0.
REQ-024 Total non-stalled FEED cycles = cols_latched+MAC_WIDTH-1, giving the staircase (pyramidal) skew.
REQ-025 wave arithmetic is unsigned CNT_W+1 bits; the maximum value cols+MAC_WIDTH-2 never wraps for legal cols.
REQ-026 DRAIN: feed_en all-zero; count exactly MAC_WIDTH cycles regardless of stall, then go to DONE.
REQ-027 DONE: done=1 for exactly one cycle; go to IDLE next cycle.
REQ-028 A start asserted in the DONE cycle is ignored; a new start is accepted from IDLE only.
REQ-029 busy=1 in REQ, FEED, DRAIN and DONE; busy=0 in IDLE.

Reset
REQ-030 reset=1 at a clock edge forces IDLE from any state, including mid-FEED or mid-DRAIN.
REQ-031 During and after reset: feed_en=0, wave=0, matrix_in_request=0, busy=0, done=0, err=0, and the latched cols is cleared.
REQ-032 reset takes priority over start, matrix_in_valid and stall in the same cycle.
REQ-033 The first start is accepted in the first cycle after reset deasserts.

Verification
REQ-034 Basic staircase: MAC_WIDTH=4, cols=3, start at cycle 0, matrix_in_valid at cycle 1, stall=0 -> FEED cycles 2-7 with feed_en 0001,0011,0111,1110,1100,1000; wave 0..5; DRAIN cycles 8-11; done=1 at cycle 12 only; busy cycles 1-12.
REQ-035 Upstream wait: matrix_in_valid held low for 5 cycles after start -> matrix_in_request high for all 6 REQ cycles; feed sequence identical to REQ-034, shifted by 5 cycles.
REQ-036 Stall mid-feed: cols=3, stall=1 for 2 cycles at wave=2 -> feed_en=0000 and wave=2 held during the stall; sequence then resumes with 0111; done is delayed by 2 cycles.
REQ-037 Illegal and ignored starts: start with cols=0 in IDLE -> err single pulse, busy stays 0; start with cols=5 during FEED -> no effect, run completes with the original cols.
REQ-038 Reset mid-operation: reset asserted at wave=3 -> next cycle all outputs 0 and state IDLE; a start with cols=1 then yields feed_en 0001,0010,0100,1000.
REQ-039 Boundary: cols=255 with CNT_W=8 -> 258 FEED cycles, final wave 257, no wrap, done asserted exactly once.

Source files
------------

// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: control/status bundle between a systolic feed sequencer and its host.
interface systolic_feed_ctrl_if #(
    parameter int MAC_WIDTH = 4,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic [CNT_W-1:0]     cols;
    logic                 matrix_in_valid;
    logic                 stall;
    logic                 matrix_in_request;
    logic [MAC_WIDTH-1:0] feed_en;
    logic [CNT_W:0]       wave;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, cols, matrix_in_valid, stall,
        input  matrix_in_request, feed_en, wave, busy, done, err
    );

    modport slave (
        input  start, cols, matrix_in_valid, stall,
        output matrix_in_request, feed_en, wave, busy, done, err
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences skewed (staircase) lane enables feeding a MAC_WIDTH-row systolic array.
module systolic_feed_ctrl #(
    parameter int MAC_WIDTH = 4,
    parameter int CNT_W     = 8
) (
    input logic                 clock,
    input logic                 reset,
    systolic_feed_ctrl_if.slave bus
);
    localparam int DW = $clog2(MAC_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, REQ, FEED, DRAIN, DONE} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] cols_q, cols_n;
    logic [CNT_W:0]   wave_q, wave_n;
    logic [DW-1:0]    drain_q, drain_n;
    logic             err_q, err_n;
    logic             last_wave;
    logic [CNT_W+1:0] w;
    logic [MAC_WIDTH-1:0] fe;

    assign last_wave = wave_q == {1'b0, cols_q} + (CNT_W+1)'(MAC_WIDTH - 2);
    assign w = {1'b0, wave_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cols_q  <= '0;
            wave_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cols_q  <= cols_n;
            wave_q  <= wave_n;
            drain_q <= drain_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cols_n  = cols_q;
        wave_n  = wave_q;
        drain_n = drain_q;
        err_n   = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.cols != '0) begin
                    cols_n  = bus.cols;
                    state_n = REQ;
                end else err_n = 1'b1;
            end
            REQ: if (bus.matrix_in_valid) begin
                state_n = FEED;
                wave_n  = '0;
            end
            FEED: if (!bus.stall) begin
                if (last_wave) begin
                    state_n = DRAIN;
                    wave_n  = '0;
                    drain_n = '0;
                end else wave_n = wave_q + 1'b1;
            end
            // drain length is fixed so stall cannot stretch the flush
            DRAIN: if (drain_q == DW'(MAC_WIDTH - 1)) state_n = DONE;
                   else drain_n = drain_q + 1'b1;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // row i is live while its column index (wave - i) lies in 0..cols-1
    always_comb begin
        fe = '0;
        for (int i = 0; i < MAC_WIDTH; i++)
            fe[i] = state == FEED && !bus.stall && w >= (CNT_W+2)'(i)
                    && w < (CNT_W+2)'(i) + (CNT_W+2)'(cols_q);
    end

    assign bus.feed_en           = fe;
    assign bus.wave              = wave_q;
    assign bus.matrix_in_request = state == REQ;
    assign bus.busy              = state != IDLE;
    assign bus.done              = state == DONE;
    assign bus.err               = err_q;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed scenario checks of the systolic feed sequencer (MAC_WIDTH=4, CNT_W=8).
module tb_systolic_feed_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    logic [16:0] obs, exp_v;

    systolic_feed_ctrl_if #(.MAC_WIDTH(4), .CNT_W(8)) bus ();
    systolic_feed_ctrl #(.MAC_WIDTH(4), .CNT_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // {request, feed_en[3:0], wave[8:0], busy, done, err}
    assign obs = {bus.matrix_in_request, bus.feed_en, bus.wave, bus.busy, bus.done, bus.err};

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] c, input logic v, input logic st);
        bus.start = s;
        bus.cols = c;
        bus.matrix_in_valid = v;
        bus.stall = st;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            cyc();
            reset = 1'b1;
            drive(1, 8'd3, 1, 1);
            #1;
            n_tests++;
            if (obs !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d got %h exp 00000", c, obs);
            end
        end
        cyc();
        reset = 1'b0;
        drive(1, 8'd1, 0, 0);
        cyc();
        drive(0, 8'd0, 0, 0);
        #1;
        exp_v = {1'b1, 4'b0, 9'd0, 1'b1, 1'b0, 1'b0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL first_start got %h exp %h", obs, exp_v);
        end
        reset = 1'b1;
        drive(1, 8'd3, 1, 0);
        cyc();
        reset = 1'b0;
        drive(0, 8'd0, 0, 0);
        #1;
        n_tests++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_from_req got %h exp 00000", obs);
        end
    endtask

    task automatic test_staircase(input int d);
        logic [3:0] stair [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        logic [3:0] fe;
        int wv;
        cyc();
        drive(1, 8'd3, 0, 0);
        #1;
        n_tests++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("FAIL stair_idle d=%0d got %h exp 00000", d, obs);
        end
        for (int c = 1; c <= 13 + d; c++) begin
            cyc();
            drive(0, 8'd0, c == 1 + d, 0);
            #1;
            fe = 4'b0;
            wv = 0;
            if (c - 2 - d >= 0 && c - 2 - d <= 5) begin
                fe = stair[c - 2 - d];
                wv = c - 2 - d;
            end
            exp_v = {c <= 1 + d, fe, 9'(wv), c <= 12 + d, c == 12 + d, 1'b0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stair d=%0d cyc %0d got %h exp %h", d, c, obs, exp_v);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] fes [8] = '{4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        int wvs [8] = '{0, 1, 2, 2, 2, 3, 4, 5};
        logic [3:0] fe;
        int wv;
        cyc();
        drive(1, 8'd3, 0, 0);
        for (int c = 1; c <= 15; c++) begin
            cyc();
            drive(0, 8'd0, c == 1, c == 4 || c == 5 || c == 11);
            #1;
            fe = 4'b0;
            wv = 0;
            if (c >= 2 && c <= 9) begin
                fe = fes[c - 2];
                wv = wvs[c - 2];
            end
            exp_v = {c == 1, fe, 9'(wv), c <= 14, c == 14, 1'b0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stall cyc %0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_illegal_and_ignored();
        logic [3:0] fe2 [5] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
        logic [3:0] fe;
        int wv;
        cyc();
        drive(1, 8'd0, 0, 0);
        cyc();
        drive(0, 8'd0, 0, 0);
        #1;
        n_tests++;
        if (obs !== 17'd1) begin
            n_fail++;
            $display("FAIL err_pulse got %h exp 00001", obs);
        end
        cyc();
        #1;
        n_tests++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("FAIL err_single got %h exp 00000", obs);
        end
        drive(1, 8'd2, 0, 0);
        for (int c = 1; c <= 13; c++) begin
            cyc();
            drive(c == 3 || c == 11, (c == 3 || c == 11) ? 8'd5 : 8'd0, c == 1, 0);
            #1;
            fe = 4'b0;
            wv = 0;
            if (c >= 2 && c <= 6) begin
                fe = fe2[c - 2];
                wv = c - 2;
            end
            exp_v = {c == 1, fe, 9'(wv), c <= 11, c == 11, 1'b0};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL ignored_start cyc %0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] fe;
        cyc();
        drive(1, 8'd3, 0, 0);
        for (int c = 1; c <= 17; c++) begin
            cyc();
            reset = c == 5;
            drive(c == 5 || c == 6, c == 6 ? 8'd1 : 8'd3, c == 1 || c == 5 || c == 7, c == 5);
            #1;
            fe = (c >= 8 && c <= 11) ? 4'(1 << (c - 8)) : 4'b0;
            if (c == 5) exp_v = {1'b0, 4'b0, 9'd3, 1'b1, 1'b0, 1'b0};
            else if (c == 6 || c == 17) exp_v = 17'd0;
            else exp_v = {c == 7, fe, (c >= 8 && c <= 11) ? 9'(c - 8) : 9'd0, 1'b1, c == 16, 1'b0};
            if (c >= 5) begin
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL reset_mid cyc %0d got %h exp %h", c, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [3:0] fe_e;
        int w;
        int dones = 0;
        int max_w = 0;
        cyc();
        drive(1, 8'd255, 0, 0);
        for (int c = 1; c <= 270; c++) begin
            cyc();
            drive(0, 8'd0, c == 1, 0);
            #1;
            dones += int'(bus.done);
            if (int'(bus.wave) > max_w) max_w = int'(bus.wave);
            if (c >= 2 && c <= 259) begin
                w = c - 2;
                if (w < 3) fe_e = 4'((1 << (w + 1)) - 1);
                else if (w < 255) fe_e = 4'b1111;
                else fe_e = 4'b1111 << (w - 254);
                n_tests++;
                if ({bus.feed_en, bus.wave} !== {fe_e, 9'(w)}) begin
                    n_fail++;
                    $display("FAIL bound_feed cyc %0d got %b/%0d exp %b/%0d", c, bus.feed_en, bus.wave, fe_e, w);
                end
            end
            if (c == 264) begin
                n_tests++;
                if (bus.done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bound_done_time got %b exp 1", bus.done);
                end
            end
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL bound_done_once got %0d exp 1", dones);
        end
        n_tests++;
        if (max_w != 257) begin
            n_fail++;
            $display("FAIL bound_max_wave got %0d exp 257", max_w);
        end
    endtask

    initial begin
        drive(0, 8'd0, 0, 0);
        test_reset();
        test_staircase(0);
        test_staircase(5);
        test_stall();
        test_illegal_and_ignored();
        test_reset_mid();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
